// File: rtl/mm_pkg.sv
// Shared types and size helpers for the matrix-multiply stream loader.
package mm_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StKick,
        StWait,
        StDrain
    } mm_ldr_state_t;

    // Default log2 of the matrix dimension N.
    localparam int unsigned MmLRamSizeDefault = 3;

    // M: words per N x N matrix.
    function automatic int unsigned mm_words(input int unsigned l_ram_size);
        return 1 << (2 * l_ram_size);
    endfunction

    // 2M: words in one operand fill (matrix A followed by matrix B).
    function automatic int unsigned mm_fill_words(input int unsigned l_ram_size);
        return 2 * mm_words(l_ram_size);
    endfunction

    // BRAM address width; covers both operand regions.
    function automatic int unsigned mm_addr_width(input int unsigned l_ram_size);
        return 2 * l_ram_size + 1;
    endfunction

endpackage

// File: rtl/mm_skid_fifo.sv
// Two-entry FIFO holding BRAM read data plus its last flag on the result path.
// The caller guarantees no push when full and no pop when empty.
module mm_skid_fifo #(
    parameter int unsigned WIDTH = 33
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;

    // Storage, pointers and occupancy; storage clears so the head reads 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/mm_stream_loader.sv
// Streams operand matrices A and B into BRAM port B, pulses the multiply engine,
// waits for done, then streams the result matrix (region A) back out.
// Optional: define MM_TLAST_CHECK_EN to flag s_tlast framing errors on err.
module mm_stream_loader
    import mm_pkg::*;
#(
    parameter int unsigned L_RAM_SIZE = MmLRamSizeDefault,
    parameter int unsigned BITWIDTH   = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [BITWIDTH-1:0]                  s_tdata,
    input  logic                                 s_tvalid,
    output logic                                 s_tready,
    input  logic                                 s_tlast,
    output logic [BITWIDTH-1:0]                  m_tdata,
    output logic                                 m_tvalid,
    input  logic                                 m_tready,
    output logic                                 m_tlast,
    output logic [mm_addr_width(L_RAM_SIZE)-1:0] bram_addr,
    output logic [BITWIDTH-1:0]                  bram_din,
    output logic                                 bram_we,
    input  logic [BITWIDTH-1:0]                  bram_dout,
    output logic                                 mm_start,
    input  logic                                 mm_done,
    output logic                                 busy,
    output logic                                 err
);

    localparam int unsigned AddrW     = mm_addr_width(L_RAM_SIZE);
    localparam int unsigned Words     = mm_words(L_RAM_SIZE);
    localparam int unsigned FillWords = mm_fill_words(L_RAM_SIZE);
    localparam logic [AddrW-1:0] LastA    = AddrW'(Words - 1);
    localparam logic [AddrW-1:0] LastFill = AddrW'(FillWords - 1);

    mm_ldr_state_t state_q, state_d;
    logic [AddrW-1:0] fill_cnt_q, fill_cnt_d;
    logic [AddrW-1:0] rd_addr_q, rd_addr_d;
    logic [AddrW-1:0] pop_cnt_q, pop_cnt_d;
    logic             inflight_q;
    logic             inflight_last_q;

    logic              fill_hs;
    logic              rd_issue;
    logic              fifo_pop;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [BITWIDTH:0] fifo_head;
    logic [2:0]        occupancy;

    assign fill_hs    = (state_q == StFill) && s_tvalid;
    assign fifo_empty = (fifo_count == 2'd0);
    assign fifo_pop   = !fifo_empty && m_tready;
    // The word leaving this cycle frees its slot, which keeps DRAIN at one word per cycle.
    assign occupancy  = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
    assign rd_issue   = (state_q == StDrain) && (rd_addr_q <= LastA) && (occupancy < 3'd2);

    // Next-state, counter updates and the combinational BRAM / handshake outputs.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        rd_addr_d  = rd_addr_q;
        pop_cnt_d  = pop_cnt_q;
        s_tready   = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_din   = '0;
        mm_start   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_tvalid) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                s_tready = 1'b1;
                if (fill_hs) begin
                    bram_we   = 1'b1;
                    bram_addr = fill_cnt_q;
                    bram_din  = s_tdata;
                    if (fill_cnt_q == LastFill) begin
                        fill_cnt_d = '0;
                        state_d    = StKick;
                    end else begin
                        fill_cnt_d = fill_cnt_q + AddrW'(1);
                    end
                end
            end
            StKick: begin
                mm_start = 1'b1;
                state_d  = StWait;
            end
            StWait: begin
                if (mm_done) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (rd_issue) begin
                    bram_addr = rd_addr_q;
                    rd_addr_d = rd_addr_q + AddrW'(1);
                end
                if (fifo_pop) begin
                    if (pop_cnt_q == LastA) begin
                        pop_cnt_d = '0;
                        rd_addr_d = '0;
                        state_d   = StIdle;
                    end else begin
                        pop_cnt_d = pop_cnt_q + AddrW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            fill_cnt_q <= '0;
            rd_addr_q  <= '0;
            pop_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            rd_addr_q  <= rd_addr_d;
            pop_cnt_q  <= pop_cnt_d;
        end
    end

    // A read issued last cycle has its data on bram_dout this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && (rd_addr_q == LastA);
        end
    end

    mm_skid_fifo #(
        .WIDTH (BITWIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight_q),
        .push_data ({inflight_last_q, bram_dout}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = m_tvalid ? fifo_head[BITWIDTH-1:0] : '0;
    assign m_tlast  = m_tvalid && fifo_head[BITWIDTH];
    assign busy     = (state_q != StIdle);

`ifdef MM_TLAST_CHECK_EN
    logic err_q;

    // Sticky flag: a fill word whose s_tlast disagrees with its position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (fill_hs && (s_tlast != (fill_cnt_q == LastFill))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_tlast;
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_mm_stream_loader.sv
// Bench for mm_stream_loader with N=2 (M=4): behavioural BRAM, behavioural engine,
// matrix-product reference model and randomized input gaps / output backpressure.
module tb_mm_stream_loader;

    localparam int unsigned BW = 32;
    localparam int unsigned M  = 4;
`ifdef MM_TLAST_CHECK_EN
    localparam bit TlastCheck = 1'b1;
`else
    localparam bit TlastCheck = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [BW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [BW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic [2:0]    bram_addr;
    logic [BW-1:0] bram_din;
    logic          bram_we;
    logic [BW-1:0] bram_dout = '0;
    logic          mm_start;
    logic          mm_done;
    logic          busy;
    logic          err;

    mm_stream_loader #(
        .L_RAM_SIZE (1),
        .BITWIDTH   (BW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .s_tlast   (s_tlast),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_we   (bram_we),
        .bram_dout (bram_dout),
        .mm_start  (mm_start),
        .mm_done   (mm_done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural dual-port BRAM plus engine model.
    logic [BW-1:0] mem [8];
    int            eng_cnt   = 0;
    int            done_left = 0;
    int            done_len  = 1;
    logic          stray_done = 1'b0;
    int            cyc = 0;

    assign mm_done = (done_left != 0) || stray_done;

    function automatic logic [BW-1:0] eng_dot(input int i, input int j);
        logic [BW-1:0] acc;
        acc = '0;
        for (int k = 0; k < 2; k++) acc = acc + mem[i*2+k] * mem[4+k*2+j];
        return acc;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
        if (reset) begin
            eng_cnt   <= 0;
            done_left <= 0;
        end else begin
            if (done_left != 0) done_left <= done_left - 1;
            if (mm_start) begin
                eng_cnt <= 3;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) begin
                    for (int i = 0; i < 2; i++)
                        for (int j = 0; j < 2; j++) mem[i*2+j] <= eng_dot(i, j);
                    done_left <= done_len;
                end
            end
        end
    end

    // Reference / scoreboard state.
    logic [BW-1:0] op_a [4];
    logic [BW-1:0] op_b [4];
    logic [BW-1:0] wr_exp [8];
    logic [BW-1:0] exp_q [$];
    int   wr_idx = 0, hs0_cyc = 0, start_cnt = 0, out_idx = 0, out_cnt = 0, done_cyc = 0;
    bit   seen_valid = 0, lat_chk = 0, exp_err = 0;
    bit   prev_stall = 0, prev_last = 0, prev_eng_done = 0;
    logic [BW-1:0] prev_data = '0;
    int   ready_mode = 0;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall    = 0;
            prev_eng_done = 0;
        end else begin
            check("err", err, exp_err);
            if (bram_we) begin
                check("we_addr", bram_addr, wr_idx);
                if (wr_idx < 8) check("we_data", bram_din, wr_exp[wr_idx]);
                if (wr_idx == 0) hs0_cyc = cyc;
                if (TlastCheck && (s_tlast != (wr_idx == 7))) exp_err = 1;
                wr_idx++;
            end
            if (mm_start) begin
                start_cnt++;
                if (lat_chk) check("start_lat", cyc - hs0_cyc, 8);
            end
            if ((done_left != 0) && !prev_eng_done) done_cyc = cyc;
            prev_eng_done = (done_left != 0);
            if (prev_stall) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", m_tdata, prev_data);
                check("hold_last", m_tlast, prev_last);
            end
            if (m_tvalid && !seen_valid) begin
                seen_valid = 1;
                if (lat_chk) check("drain_lat", cyc - done_cyc, 3);
            end
            if (m_tvalid && m_tready) begin
                check("out_avail", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("out_data", m_tdata, exp_q.pop_front());
                    check("out_last", m_tlast, out_idx == M - 1);
                end
                out_idx = (out_idx + 1) % M;
                out_cnt++;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_tready = 1'b1;
                1: begin
                    m_tready = ((ph % 4) == 0) || ((ph % 4) == 3);
                    ph++;
                end
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_tready"}, s_tready, 0);
        check({tag, "_m_tvalid"}, m_tvalid, 0);
        check({tag, "_m_tdata"}, m_tdata, 0);
        check({tag, "_m_tlast"}, m_tlast, 0);
        check({tag, "_bram_addr"}, bram_addr, 0);
        check({tag, "_bram_din"}, bram_din, 0);
        check({tag, "_bram_we"}, bram_we, 0);
        check({tag, "_mm_start"}, mm_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic send_word(input logic [BW-1:0] w, input logic last);
        bit hs;
        int n;
        s_tvalid = 1'b1;
        s_tdata  = w;
        s_tlast  = last;
        hs = 0;
        n  = 0;
        do begin
            @(negedge clk);
            hs = s_tready;
            @(posedge clk);
            #1;
            n++;
        end while (!hs && n < 50);
        check("s_hs", hs, 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // One transfer; stop_after >= 0 asserts reset after that many results.
    task automatic run_xfer(input bit gaps, input int rmode, input int dlen, input int bad_last,
                            input bit stray, input bit junk, input int stop_after);
        logic [BW-1:0] acc;
        int target, n;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                acc = '0;
                for (int k = 0; k < 2; k++) acc = acc + op_a[i*2+k] * op_b[k*2+j];
                exp_q.push_back(acc);
            end
        for (int i = 0; i < 8; i++) wr_exp[i] = (i < 4) ? op_a[i] : op_b[i-4];
        wr_idx = 0; start_cnt = 0; out_idx = 0; out_cnt = 0; seen_valid = 0;
        lat_chk = !gaps && !stray && (rmode == 0);
        ready_mode = rmode;
        done_len = dlen;
        for (int i = 0; i < 8; i++) begin
            if (stray && i == 3) begin
                stray_done = 1'b1;
                @(posedge clk);
                #1;
                stray_done = 1'b0;
            end
            send_word(wr_exp[i], (bad_last >= 0) ? (i == bad_last) : (i == 7));
            if (gaps) begin
                @(posedge clk);
                #1;
            end
        end
        if (junk) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hdead_beef;
            n = 0;
            while (!seen_valid && n < 100) begin
                @(negedge clk);
                check("s_tready_busy", s_tready, 0);
                @(posedge clk);
                #1;
                n++;
            end
            s_tvalid = 1'b0;
        end
        target = (stop_after < 0) ? M : stop_after;
        n = 0;
        while (out_cnt < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("out_count", out_cnt, target);
        if (stop_after >= 0) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            #1;
            check_reset_vals("mid_rst");
            exp_q.delete();
            exp_err = 0;
            @(posedge clk);
            #1;
            reset = 1'b0;
        end else begin
            repeat (3) @(posedge clk);
            #1;
            check("end_busy", busy, 0);
            check("start_cnt", start_cnt, 1);
            check("wr_count", wr_idx, 8);
            check("exp_left", exp_q.size(), 0);
        end
    endtask

    initial begin
        #3;
        check_reset_vals("por");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        op_a = '{1, 0, 0, 1}; op_b = '{5, 6, 7, 8};
        run_xfer(0, 0, 1, -1, 0, 0, -1);
        op_a = '{2, 0, 0, 2}; op_b = '{1, 2, 3, 4};
        run_xfer(0, 1, 1, -1, 0, 0, -1);
        op_a = '{3, 1, 4, 1}; op_b = '{5, 9, 2, 6};
        run_xfer(1, 0, 1, -1, 0, 0, -1);
        op_a = '{7, 2, 1, 8}; op_b = '{2, 8, 1, 8};
        run_xfer(0, 0, 5, -1, 1, 1, -1);
        op_a = '{1, 2, 3, 4}; op_b = '{4, 3, 2, 1};
        run_xfer(0, 0, 1, -1, 0, 0, 2);
        op_a = '{9, 0, 1, 5}; op_b = '{6, 2, 7, 3};
        run_xfer(0, 0, 1, -1, 0, 0, -1);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 4; i++) begin
                op_a[i] = $urandom_range(0, 255);
                op_b[i] = $urandom_range(0, 255);
            end
            run_xfer(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 5),
                     -1, 0, 0, -1);
        end

        op_a = '{1, 0, 0, 1}; op_b = '{11, 12, 13, 14};
        run_xfer(0, 0, 1, 5, 0, 0, -1);
        check("err_sticky", err, TlastCheck);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
